// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl: 4-digit FND scan controller with inter-digit blanking.
// Optional leading-zero blanking when FND_LEADING_ZERO_BLANK_EN is defined.
module fnd_scan_ctrl #(
   parameter int CLK_HZ       = 100_000_000,
   parameter int SCAN_HZ      = 1000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_enable,
   input  logic [3:0] i_four,
   input  logic [3:0] i_three,
   input  logic [3:0] i_two,
   output logic [1:0] o_digit,
   output logic [3:0] o_fnd_com,
   output logic       o_scan_tick
);
   localparam int DIV = CLK_HZ / SCAN_HZ;
   localparam int CW  = $clog2(DIV);
   typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;
   state_t        r_state, w_state_nx;
   logic [CW-1:0] r_pre, w_pre_nx, r_blk, w_blk_nx;
   logic [1:0]    r_digit, w_digit_nx;
   logic [3:0]    r_com, w_com_nx;
   logic          r_tick, w_tick_nx;
   logic          w_wrap, w_dark;
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= IDLE;
         r_pre   <= '0;
         r_blk   <= '0;
         r_digit <= 2'd0;
         r_com   <= 4'b1111;
         r_tick  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_pre   <= w_pre_nx;
         r_blk   <= w_blk_nx;
         r_digit <= w_digit_nx;
         r_com   <= w_com_nx;
         r_tick  <= w_tick_nx;
      end
   end
   always_comb begin
      w_wrap     = r_pre == CW'(DIV - 1);
      w_state_nx = r_state;
      w_pre_nx   = '0;
      w_blk_nx   = '0;
      w_digit_nx = r_digit;
      w_tick_nx  = 1'b0;
      if (!i_enable) begin
         w_state_nx = IDLE;
         w_digit_nx = 2'd0;
      end else begin
         case (r_state)
            IDLE: begin
               w_state_nx = (BLANK_CYCLES == 0) ? ON : BLANK;
               w_digit_nx = 2'd0;
            end
            BLANK: begin
               w_pre_nx   = w_wrap ? '0 : r_pre + 1'b1;
               w_blk_nx   = r_blk + 1'b1;
               if (r_blk == CW'(BLANK_CYCLES - 1)) begin
                  w_state_nx = ON;
                  w_blk_nx   = '0;
               end
            end
            ON: begin
               w_pre_nx = w_wrap ? '0 : r_pre + 1'b1;
               if (w_wrap) begin
                  w_digit_nx = r_digit + 2'd1;
                  w_tick_nx  = 1'b1;
                  w_state_nx = (BLANK_CYCLES == 0) ? ON : BLANK;
               end
            end
            default: begin
               w_state_nx = IDLE;
               w_digit_nx = 2'd0;
            end
         endcase
      end
`ifdef FND_LEADING_ZERO_BLANK_EN
      w_dark = (w_digit_nx == 2'd3 && i_four == 4'd0)
            || (w_digit_nx == 2'd2 && i_four == 4'd0 && i_three == 4'd0)
            || (w_digit_nx == 2'd1 && ~|{i_four, i_three, i_two});
`else
      w_dark = 1'b0;
`endif
      w_com_nx = (w_state_nx == ON && !w_dark) ? ~(4'b0001 << w_digit_nx) : 4'b1111;
   end
`ifndef FND_LEADING_ZERO_BLANK_EN
   logic w_unused;
   assign w_unused = ^{i_four, i_three, i_two};
`endif
   assign o_digit     = r_digit;
   assign o_fnd_com   = r_com;
   assign o_scan_tick = r_tick;
endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// tb_fnd_scan_ctrl: directed checks of scan order, blanking, enable drop, reset and leading zeros.
module tb_fnd_scan_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic [3:0] four = 4'd1, three = 4'd2, two = 4'd3;
   logic [1:0] dig, dig0;
   logic [3:0] com, com0;
   logic       tick, tick0;
   int         total = 0;
   int         bad = 0;
`ifdef FND_LEADING_ZERO_BLANK_EN
   localparam logic [3:0] LZ_MASK = 4'b1100;
`else
   localparam logic [3:0] LZ_MASK = 4'b0000;
`endif
   always #5 clk = ~clk;
   fnd_scan_ctrl #(.CLK_HZ(1000), .SCAN_HZ(100), .BLANK_CYCLES(2)) u_dut (
      .i_clk(clk), .i_reset(rst), .i_enable(en), .i_four(four), .i_three(three), .i_two(two),
      .o_digit(dig), .o_fnd_com(com), .o_scan_tick(tick));
   fnd_scan_ctrl #(.CLK_HZ(1000), .SCAN_HZ(100), .BLANK_CYCLES(0)) u_dut0 (
      .i_clk(clk), .i_reset(rst), .i_enable(en), .i_four(four), .i_three(three), .i_two(two),
      .o_digit(dig0), .o_fnd_com(com0), .o_scan_tick(tick0));
   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic check_idle(input string tag);
      check({tag, " digit"}, {2'b0, dig}, 4'd0);
      check({tag, " com"}, com, 4'b1111);
      check({tag, " tick"}, {3'b0, tick}, 4'd0);
      check({tag, " digit0"}, {2'b0, dig0}, 4'd0);
      check({tag, " com0"}, com0, 4'b1111);
      check({tag, " tick0"}, {3'b0, tick0}, 4'd0);
   endtask
   // j counts edges since the enabling edge: digit = j/10 mod 4, blank while j mod 10 < 2
   task automatic run_scan(input int n, input logic [3:0] dark);
      logic [1:0] d;
      int         ph;
      logic [3:0] ec, ec0;
      for (int j = 0; j < n; j++) begin
         step();
         d   = 2'((j / 10) % 4);
         ph  = j % 10;
         ec  = (ph < 2 || dark[d]) ? 4'b1111 : ~(4'b0001 << d);
         ec0 = dark[d] ? 4'b1111 : ~(4'b0001 << d);
         check($sformatf("digit j=%0d", j), {2'b0, dig}, {2'b0, d});
         check($sformatf("com j=%0d", j), com, ec);
         check($sformatf("tick j=%0d", j), {3'b0, tick}, {3'b0, (j > 0 && ph == 0)});
         check($sformatf("digit0 j=%0d", j), {2'b0, dig0}, {2'b0, d});
         check($sformatf("com0 j=%0d", j), com0, ec0);
         check($sformatf("tick0 j=%0d", j), {3'b0, tick0}, {3'b0, (j > 0 && ph == 0)});
      end
   endtask
   initial begin
      repeat (3) begin
         step();
         check_idle("reset");
      end
      rst = 1'b0;
      en  = 1'b1;
      run_scan(65, 4'b0000);
      en = 1'b0;
      step();
      check_idle("enable_drop");
      step();
      check_idle("idle_hold");
      en = 1'b1;
      run_scan(36, 4'b0000);
      rst = 1'b1;
      step();
      check_idle("midscan_reset");
      rst   = 1'b0;
      en    = 1'b0;
      four  = 4'd0;
      three = 4'd0;
      two   = 4'd5;
      step();
      check_idle("post_reset_idle");
      en = 1'b1;
      run_scan(40, LZ_MASK);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
